bram_uart_feeder: RTL and testbench



---
 rtl/bram_uart_pkg.sv | 34 +++
 rtl/bram_uart_feeder_if.sv | 34 +++
 rtl/bram_uart_feeder.sv | 139 +++++++++++++
 tb/tb_bram_uart_feeder.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_uart_pkg.sv
// Shared constants for the BRAM-to-UART path.
// Feeder FSM encoding and baud timing at 125 MHz.
package bram_uart_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int CLKS_PER_BIT = 1085;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_READ     = 3'd1;
    localparam logic [2:0] ST_WAIT_RD  = 3'd2;
    localparam logic [2:0] ST_LOAD     = 3'd3;
    localparam logic [2:0] ST_KICK     = 3'd4;
    localparam logic [2:0] ST_WAIT_RFN = 3'd5;
    localparam logic [2:0] ST_NEXT     = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        READ     = ST_READ,
        WAIT_RD  = ST_WAIT_RD,
        LOAD     = ST_LOAD,
        KICK     = ST_KICK,
        WAIT_RFN = ST_WAIT_RFN,
        NEXT     = ST_NEXT,
        DONE     = ST_DONE
    } feeder_state_e;

    function automatic int cnt_width(input int rd_lat, input int ntx);
        int m;
        m = (rd_lat > ntx) ? rd_lat : ntx;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bram_uart_feeder_if.sv
// Feeder-side bundle: BRAM read port plus transmitter handshake.
// master = feeder, slave = BRAM/transmitter side.
interface bram_uart_feeder_if
    import bram_uart_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              o_bram_en;
    logic [ADDR_W-1:0] o_bram_addr;
    logic [7:0]        i_bram_dout;
    logic [7:0]        o_data;
    logic              o_nTx_EN;
    logic              i_RFN;

    modport master (
        output o_bram_en,
        output o_bram_addr,
        input  i_bram_dout,
        output o_data,
        output o_nTx_EN,
        input  i_RFN
    );

    modport slave (
        input  o_bram_en,
        input  o_bram_addr,
        output i_bram_dout,
        input  o_data,
        input  o_nTx_EN,
        output i_RFN
    );

endinterface

// File: rtl/bram_uart_feeder.sv
// Reads a run of bytes from a sync-read BRAM and hands them one
// at a time to the UART transmitter, pacing on its RFN pulse.
module bram_uart_feeder
    import bram_uart_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int RD_LAT    = 1,
    parameter int NTX_PULSE = 2
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_len,
    bram_uart_feeder_if.master bus,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W = cnt_width(RD_LAT, NTX_PULSE);

    localparam logic [CNT_W-1:0] RD_END =
        CNT_W'((RD_LAT > 1) ? (RD_LAT - 2) : 0);
    localparam logic [CNT_W-1:0] TX_END =
        CNT_W'(NTX_PULSE - 1);

    localparam logic [ADDR_W:0] LEN_ONE =
        {{ADDR_W{1'b0}}, 1'b1};

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
        $error("RD_LAT out of range 1..3");
    end
    if (NTX_PULSE < 1) begin : g_bad_pulse
        $error("NTX_PULSE must be at least 1");
    end

    feeder_state_e     state;
    feeder_state_e     state_nx;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        data_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        bus.o_bram_en   = 1'b0;
        bus.o_bram_addr = addr;
        bus.o_data      = data_q;
        bus.o_nTx_EN    = 1'b1;
        o_busy          = 1'b1;
        o_done          = 1'b0;
        unique case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_nx = (i_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                bus.o_bram_en = 1'b1;
                state_nx = (RD_LAT == 1) ? LOAD : WAIT_RD;
            end
            WAIT_RD: begin
                if (cnt == RD_END) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                state_nx = KICK;
            end
            KICK: begin
                bus.o_nTx_EN = 1'b0;
                if (cnt == TX_END) begin
                    state_nx = WAIT_RFN;
                end
            end
            WAIT_RFN: begin
                if (bus.i_RFN) begin
                    state_nx = NEXT;
                end
            end
            NEXT: begin
                state_nx = (remaining == LEN_ONE) ? DONE : READ;
            end
            DONE: begin
                o_busy   = 1'b0;
                o_done   = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    // One counter serves both the read-latency wait and the pulse width.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            addr      <= '0;
            remaining <= '0;
            cnt       <= '0;
            data_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_start && i_len != '0) begin
                        addr      <= i_base;
                        remaining <= i_len;
                    end
                end
                READ: begin
                    cnt <= '0;
                end
                WAIT_RD: begin
                    cnt <= cnt + 1'b1;
                end
                LOAD: begin
                    cnt    <= '0;
                    data_q <= bus.i_bram_dout;
                end
                KICK: begin
                    cnt <= cnt + 1'b1;
                end
                NEXT: begin
                    remaining <= remaining - 1'b1;
                    addr      <= addr + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_uart_feeder.sv
// Bench for bram_uart_feeder: one default instance for directed
// scenarios, two more with other RD_LAT/NTX_PULSE for the sweep.
module tb_bram_uart_feeder;
    import bram_uart_pkg::*;

    localparam int AW  = ADDR_W_DEF;
    localparam int NI  = 3;
    localparam int LOG = 2048;
    localparam int MSZ = 1 << AW;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic rst_n;
    logic [7:0] mem [MSZ];

    logic          start  [NI];
    logic [AW-1:0] base_v [NI];
    logic [AW:0]   len_v  [NI];
    logic          man_rfn [NI];
    logic          auto_rfn [NI];
    bit            auto_en [NI];

    logic          en   [NI];
    logic [AW-1:0] addr [NI];
    logic [7:0]    data [NI];
    logic          ntx  [NI];
    logic          busy [NI];
    logic          done [NI];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] rd_addr [NI][LOG];
    int            rd_cyc  [NI][LOG];
    int            rd_n    [NI];
    logic [7:0]    p_data  [NI][LOG];
    int            p_w     [NI][LOG];
    int            p_cyc   [NI][LOG];
    int            p_n     [NI];
    int            done_n  [NI];
    int            done_cyc [NI];
    int            rfn_cyc [NI][LOG];
    int            rfn_n   [NI] = '{0, 0, 0};

    int passed = 0;
    int total  = 0;

    function automatic int rl_of(input int g);
        return g + 1;
    endfunction

    function automatic int np_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int RLG = g + 1;
        localparam int NPG = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

        bram_uart_feeder_if #(.ADDR_W(AW)) bus ();
        logic [7:0] pipe [1:3];

        always @(posedge clk) begin
            if (bus.o_bram_en) pipe[1] <= mem[bus.o_bram_addr];
            pipe[2] <= pipe[1];
            pipe[3] <= pipe[2];
        end

        assign bus.i_bram_dout = pipe[RLG];
        assign bus.i_RFN       = man_rfn[g] | auto_rfn[g];
        assign en[g]           = bus.o_bram_en;
        assign addr[g]         = bus.o_bram_addr;
        assign data[g]         = bus.o_data;
        assign ntx[g]          = bus.o_nTx_EN;

        bram_uart_feeder #(
            .ADDR_W   (AW),
            .RD_LAT   (RLG),
            .NTX_PULSE(NPG)
        ) dut (
            .clk    (clk),
            .nRst   (rst_n),
            .i_start(start[g]),
            .i_base (base_v[g]),
            .i_len  (len_v[g]),
            .bus    (bus),
            .o_busy (busy[g]),
            .o_done (done[g])
        );
    end

    // RFN as seen by the DUT, logged at the edge that samples it.
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (man_rfn[g] | auto_rfn[g]) begin
                rfn_cyc[g][rfn_n[g] % LOG] <= cyc;
                rfn_n[g] <= rfn_n[g] + 1;
            end
        end
    end

    // Observer plus auto-responder issuing RFN 0..4 cycles after each pulse.
    initial begin
        int low_w [NI];
        int dly   [NI];
        bit armed [NI];
        for (int g = 0; g < NI; g++) begin
            auto_rfn[g] = 1'b0;
            rd_n[g] = 0; p_n[g] = 0; done_n[g] = 0; done_cyc[g] = 0;
            low_w[g] = 0; dly[g] = 0; armed[g] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                auto_rfn[g] = 1'b0;
                if (en[g]) begin
                    rd_addr[g][rd_n[g] % LOG] = addr[g];
                    rd_cyc[g][rd_n[g] % LOG]  = cyc;
                    rd_n[g]++;
                end
                if (done[g]) begin
                    done_n[g]++;
                    done_cyc[g] = cyc;
                end
                if (!ntx[g]) begin
                    if (low_w[g] == 0) begin
                        p_cyc[g][p_n[g] % LOG]  = cyc;
                        p_data[g][p_n[g] % LOG] = data[g];
                    end
                    low_w[g]++;
                end else if (low_w[g] != 0) begin
                    p_w[g][p_n[g] % LOG] = low_w[g];
                    p_n[g]++;
                    low_w[g] = 0;
                    if (auto_en[g]) begin
                        armed[g] = 1'b1;
                        dly[g] = $urandom_range(0, 4);
                    end
                end
                if (armed[g]) begin
                    if (dly[g] == 0) begin
                        auto_rfn[g] = 1'b1;
                        armed[g] = 1'b0;
                    end else begin
                        dly[g]--;
                    end
                end
            end
        end
    end

    task automatic do_start(input int g, input logic [AW-1:0] b,
                            input logic [AW:0] l, output int s);
        @(negedge clk); #1;
        start[g] = 1'b1; base_v[g] = b; len_v[g] = l; s = cyc;
        @(negedge clk); #1;
        start[g] = 1'b0;
        base_v[g] = AW'($urandom);
        len_v[g] = (AW+1)'($urandom);
    endtask

    task automatic wait_done(input int g, input int d0,
                             input int budget, output bit ok);
        int n;
        n = 0; ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk); #1;
            n++;
            if (done_n[g] > d0) ok = 1'b1;
        end
    endtask

    task automatic wait_pulses(input int g, input int target,
                               input int budget, output bit ok);
        int n;
        n = 0; ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk); #1;
            n++;
            if (p_n[g] >= target) ok = 1'b1;
        end
    endtask

    task automatic pulse_rfn(input int g, output int c);
        @(negedge clk); #1;
        man_rfn[g] = 1'b1; c = cyc;
        @(negedge clk); #1;
        man_rfn[g] = 1'b0;
    endtask

    // Whole run with auto RFN, checked against mem[(base+k) mod 2^AW].
    task automatic run_checked(input int g, input logic [AW-1:0] b,
                               input int l, input string tag);
        int r0, p0, f0, d0, s, nr, np, m, ea, er, ed;
        int bad_a, bad_d, bad_w, bad_t;
        bit ok;
        r0 = rd_n[g]; p0 = p_n[g]; f0 = rfn_n[g]; d0 = done_n[g];
        bad_a = 0; bad_d = 0; bad_w = 0; bad_t = 0;
        auto_en[g] = 1'b1;
        do_start(g, b, (AW+1)'(l), s);
        wait_done(g, d0, l * 40 + 100, ok);
        repeat (2) @(negedge clk);
        #1;
        auto_en[g] = 1'b0;
        nr = rd_n[g] - r0; np = p_n[g] - p0;
        total++;
        if (!ok) $display("FAIL %s done: not seen, required one pulse", tag);
        else passed++;
        total++;
        if (nr != l) $display("FAIL %s reads: got %0d required %0d", tag, nr, l);
        else passed++;
        total++;
        if (np != l) $display("FAIL %s pulses: got %0d required %0d", tag, np, l);
        else passed++;
        m = l;
        if (nr < m) m = nr;
        if (np < m) m = np;
        for (int k = 0; k < m; k++) begin
            ea = (int'(b) + k) % MSZ;
            if (rd_addr[g][(r0+k) % LOG] !== ea[AW-1:0]) bad_a++;
            if (p_data[g][(p0+k) % LOG] !== mem[ea]) bad_d++;
            if (p_w[g][(p0+k) % LOG] != np_of(g)) bad_w++;
            er = (k == 0) ? s + 1 : rfn_cyc[g][(f0+k-1) % LOG] + 2;
            if (rd_cyc[g][(r0+k) % LOG] != er) bad_t++;
            if (p_cyc[g][(p0+k) % LOG] != rd_cyc[g][(r0+k) % LOG] + rl_of(g) + 1)
                bad_t++;
        end
        total++;
        if (bad_a != 0) $display("FAIL %s addr_seq: %0d wrong, required 0", tag, bad_a);
        else passed++;
        total++;
        if (bad_d != 0) $display("FAIL %s data_seq: %0d wrong, required 0", tag, bad_d);
        else passed++;
        total++;
        if (bad_w != 0) $display("FAIL %s ntx_width: %0d wrong, required 0", tag, bad_w);
        else passed++;
        total++;
        if (bad_t != 0) $display("FAIL %s timing: %0d wrong, required 0", tag, bad_t);
        else passed++;
        ed = (rfn_n[g] - f0 >= l) ? rfn_cyc[g][(f0+l-1) % LOG] + 2 : -1;
        total++;
        if (done_cyc[g] != ed || done_n[g] - d0 != 1)
            $display("FAIL %s done_at: cycle %0d count %0d, required cycle %0d count 1",
                     tag, done_cyc[g], done_n[g] - d0, ed);
        else passed++;
        total++;
        if (busy[g] !== 1'b0) $display("FAIL %s busy_end: got %b required 0", tag, busy[g]);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (en[0] !== 1'b0) $display("FAIL rst_en: got %b required 0", en[0]);
        else passed++;
        total++;
        if (addr[0] !== '0) $display("FAIL rst_addr: got %h required 0", addr[0]);
        else passed++;
        total++;
        if (data[0] !== 8'h00) $display("FAIL rst_data: got %h required 00", data[0]);
        else passed++;
        total++;
        if (ntx[0] !== 1'b1) $display("FAIL rst_ntx: got %b required 1", ntx[0]);
        else passed++;
        total++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0)
            $display("FAIL rst_busy_done: got %b%b required 00", busy[0], done[0]);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int r0, p0, d0, s, c;
        bit ok;
        mem[5] = 8'h44;
        r0 = rd_n[0]; p0 = p_n[0]; d0 = done_n[0];
        do_start(0, AW'(5), (AW+1)'(1), s);
        wait_pulses(0, p0 + 1, 20, ok);
        total++;
        if (!ok || rd_n[0] - r0 != 1 || rd_addr[0][r0 % LOG] !== AW'(5))
            $display("FAIL single_read: reads %0d addr %h, required 1 at 005",
                     rd_n[0] - r0, rd_addr[0][r0 % LOG]);
        else passed++;
        total++;
        if (p_data[0][p0 % LOG] !== 8'h44)
            $display("FAIL single_data: got %h required 44", p_data[0][p0 % LOG]);
        else passed++;
        total++;
        if (p_w[0][p0 % LOG] != 2)
            $display("FAIL single_width: got %0d required 2", p_w[0][p0 % LOG]);
        else passed++;
        repeat (40) @(negedge clk);
        #1;
        total++;
        if (busy[0] !== 1'b1 || done_n[0] != d0)
            $display("FAIL single_hold: busy %b dones %0d, required busy 1 dones 0",
                     busy[0], done_n[0] - d0);
        else passed++;
        pulse_rfn(0, c);
        wait_done(0, d0, 10, ok);
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (!ok || done_cyc[0] != c + 2 || done_n[0] - d0 != 1)
            $display("FAIL single_done: cycle %0d count %0d, required cycle %0d count 1",
                     done_cyc[0], done_n[0] - d0, c + 2);
        else passed++;
        total++;
        if (busy[0] !== 1'b0 || data[0] !== 8'h44)
            $display("FAIL single_after: busy %b data %h, required 0 44", busy[0], data[0]);
        else passed++;
    endtask

    task automatic test_run3();
        mem['h10] = 8'h44;
        mem['h11] = 8'h5A;
        mem['h12] = 8'h21;
        run_checked(0, AW'('h10), 3, "run3");
    endtask

    task automatic test_zero();
        int r0, p0, d0, s;
        bit seen_busy;
        logic [7:0] d_before;
        d_before = data[0];
        r0 = rd_n[0]; p0 = p_n[0]; d0 = done_n[0]; seen_busy = 1'b0;
        do_start(0, AW'($urandom), '0, s);
        repeat (5) begin
            if (busy[0] !== 1'b0) seen_busy = 1'b1;
            @(negedge clk); #1;
        end
        total++;
        if (done_n[0] - d0 != 1 || done_cyc[0] != s + 1)
            $display("FAIL zero_done: count %0d cycle %0d, required 1 at %0d",
                     done_n[0] - d0, done_cyc[0], s + 1);
        else passed++;
        total++;
        if (rd_n[0] != r0 || p_n[0] != p0)
            $display("FAIL zero_quiet: reads %0d pulses %0d, required 0 0",
                     rd_n[0] - r0, p_n[0] - p0);
        else passed++;
        total++;
        if (seen_busy || data[0] !== d_before)
            $display("FAIL zero_keep: busy seen %b data %h, required 0 %h",
                     seen_busy, data[0], d_before);
        else passed++;
    endtask

    task automatic test_abuse();
        int r0, p0, d0, s, n, c;
        bit ok;
        logic [AW-1:0] b, b1;
        b = AW'($urandom); b1 = b + 1'b1;
        r0 = rd_n[0]; p0 = p_n[0]; d0 = done_n[0];
        do_start(0, b, (AW+1)'(2), s);
        n = 0;
        while (ntx[0] !== 1'b0 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        man_rfn[0] = 1'b1;
        start[0] = 1'b1; base_v[0] = b ^ AW'('h155); len_v[0] = (AW+1)'(7);
        @(negedge clk); #1;
        man_rfn[0] = 1'b0; start[0] = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        total++;
        if (rd_n[0] - r0 != 1 || busy[0] !== 1'b1 || done_n[0] != d0)
            $display("FAIL abuse_stall: reads %0d busy %b dones %0d, required 1 1 0",
                     rd_n[0] - r0, busy[0], done_n[0] - d0);
        else passed++;
        pulse_rfn(0, c);
        wait_pulses(0, p0 + 2, 20, ok);
        total++;
        if (!ok || rd_addr[0][(r0+1) % LOG] !== b1 || p_data[0][(p0+1) % LOG] !== mem[b1])
            $display("FAIL abuse_second: addr %h data %h, required %h %h",
                     rd_addr[0][(r0+1) % LOG], p_data[0][(p0+1) % LOG], b1, mem[b1]);
        else passed++;
        pulse_rfn(0, c);
        start[0] = 1'b1; base_v[0] = b; len_v[0] = (AW+1)'(3);
        @(negedge clk); #1;
        start[0] = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        total++;
        if (done_n[0] - d0 != 1 || done_cyc[0] != c + 2)
            $display("FAIL abuse_done: count %0d cycle %0d, required 1 at %0d",
                     done_n[0] - d0, done_cyc[0], c + 2);
        else passed++;
        total++;
        if (rd_n[0] - r0 != 2 || busy[0] !== 1'b0)
            $display("FAIL abuse_start_in_done: reads %0d busy %b, required 2 0",
                     rd_n[0] - r0, busy[0]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int s, n;
        do_start(0, AW'($urandom), (AW+1)'(3), s);
        n = 0;
        while (ntx[0] !== 1'b0 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (ntx[0] !== 1'b1) $display("FAIL mid_rst_ntx: got %b required 1", ntx[0]);
        else passed++;
        total++;
        if (en[0] !== 1'b0 || addr[0] !== '0 || data[0] !== 8'h00 ||
            busy[0] !== 1'b0 || done[0] !== 1'b0)
            $display("FAIL mid_rst_outs: en %b addr %h data %h busy %b done %b, required 0 000 00 0 0",
                     en[0], addr[0], data[0], busy[0], done[0]);
        else passed++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_checked(0, AW'($urandom), $urandom_range(1, 6), "after_rst");
    endtask

    task automatic test_sweep();
        logic [AW-1:0] b1, b2;
        int l1, l2;
        for (int r = 0; r < 3; r++) begin
            b1 = (r == 2) ? AW'(MSZ - 3) : AW'($urandom);
            b2 = (r == 2) ? AW'(MSZ - 2) : AW'($urandom);
            l1 = $urandom_range(1, 10);
            l2 = $urandom_range(1, 10);
            fork
                run_checked(1, b1, l1, "sweep_l2_p1");
                run_checked(2, b2, l2, "sweep_l3_p4");
            join
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < NI; g++) begin
            start[g] = 1'b0; base_v[g] = '0; len_v[g] = '0;
            man_rfn[g] = 1'b0; auto_en[g] = 1'b0;
        end
        for (int i = 0; i < MSZ; i++) mem[i] = 8'($urandom);

        test_reset();
        test_single();
        test_run3();
        run_checked(0, AW'('h3FE), 4, "wrap");
        test_zero();
        test_abuse();
        test_reset_mid();
        for (int i = 0; i < 3; i++)
            run_checked(0, AW'($urandom), $urandom_range(1, 12), "random");
        run_checked(0, AW'($urandom), MSZ, "full_wrap");
        test_sweep();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
